rsa_avm_wrapper: RTL
====================

Name: rsa_avm_wrapper

Overview:
- Avalon-MM master that connects the RSA256 core to an RS232 UART peripheral.
- Loads key N (32 bytes), exponent D (32 bytes), then ciphertext A (32 bytes) from UART RX, MSB byte first.
- Pulses core start, waits for core finished, then writes the low OUT_BYTES bytes of the result to UART TX, MSB first.
- Keeps N/D and loops on further ciphertext blocks until reset. Acts as the initiator/driver end of the core's start/finished interface.

Parameters:
- RX_BASE, 0, UART RX data register word address
- TX_BASE, 1, UART TX data register word address
- STATUS_BASE, 2, UART status register word address
- RX_OK_BIT, 7, status bit: RX byte available
- TX_OK_BIT, 6, status bit: TX ready
- IN_BYTES, 32, bytes per N/D/A operand
- OUT_BYTES, 31, result bytes sent (result < N, top byte dropped)

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- o_avm_address  out  5  Avalon word address
- o_avm_read  out  1  Avalon read request
- i_avm_readdata  in  32  Avalon read data (byte in [7:0])
- o_avm_write  out  1  Avalon write request
- o_avm_writedata  out  32  Avalon write data ({24'b0, byte})
- i_avm_waitrequest  in  1  slave stall
- o_core_start  out  1  one-cycle core start pulse
- o_core_a  out  256  ciphertext to core
- o_core_d  out  256  exponent to core
- o_core_n  out  256  modulus to core
- i_core_result  in  256  core result (a^d mod n)
- i_core_finished  in  1  core done pulse

Behaviour:
- Reset values: address=STATUS_BASE; read=0; write=0; writedata=0; core_start=0; n/d/a regs=0; phase=LOAD_N; byte counter=0; state=S_QUERY_RX.
- Avalon rule: address/read/write/writedata are held stable while waitrequest=1. A transfer completes in the first cycle with request high and waitrequest=0. Read and write are never asserted together.
- S_QUERY_RX: read=1 at STATUS_BASE. On completion:
  - readdata[RX_OK_BIT]=1: drop read, next state S_READ.
  - Otherwise: drop read for one cycle, then re-issue the query.
- S_READ: read=1 at RX_BASE. On completion, shift the target reg left 8 and insert readdata[7:0]. Target reg is N, D or A per phase.
  - Counter < IN_BYTES-1: counter+1, back to S_QUERY_RX.
  - Counter = IN_BYTES-1: counter=0.
    - Phase N goes to phase D.
    - Phase D goes to phase A.
    - Phase A: next state S_START.
- S_START: o_core_start=1 for exactly one cycle, next state S_WAIT_CALC.
- S_WAIT_CALC: hold o_core_a/d/n stable. On i_core_finished=1, latch the result into the output shift reg, counter=0, next state S_QUERY_TX.
  - Finished asserted in any other state is ignored.
- S_QUERY_TX: read STATUS_BASE. On completion with readdata[TX_OK_BIT]=1, next state S_WRITE; otherwise retry as in RX.
- S_WRITE: write=1 at TX_BASE, writedata = result byte (OUT_BYTES-1-counter).
  - On completion with counter < OUT_BYTES-1: counter+1, back to S_QUERY_TX.
  - On completion with counter = OUT_BYTES-1: counter=0, phase stays A, next state S_QUERY_RX for the next ciphertext. N and D are retained.
- Minimum latency: 2 Avalon transfers per byte. With zero waitrequest, at least 4 cycles per byte including the request-drop cycles.
- Reset mid-operation (any state, including during a stalled transfer): all registers return to reset values next cycle and read/write drop immediately. The bench need not complete the pending transfer.
- Operand regs are exactly 256 bits. Shifting discards the top byte, so if more than IN_BYTES are received (not possible by construction), the newest 32 are kept.

Decomposition:
- Shared package rsa_pkg: state enum (S_QUERY_RX, S_READ, S_START, S_WAIT_CALC, S_QUERY_TX, S_WRITE), phase enum (LOAD_N, LOAD_D, LOAD_A), default UART address/bit constants.
- Single module; no sub-module needed. The core is instantiated alongside this block at the top level.

Test Plan:
- Zero-wait UART, RX always ready. Send N=33, D=7, A=5 as 32-byte big-endian streams. Core model returns 14 after 10 cycles. Expect exactly one start pulse with o_core_n=33, o_core_d=7, o_core_a=5, then 31 TX writes of 0x00…00,0x0E.
- RX status reads 0 for the first 5 polls of each byte → same result. No RX_BASE read is ever issued while status bit 7=0.
- waitrequest held high 3 cycles on every transfer → address/read/write/writedata constant during the stall, and exactly one byte consumed per RX_BASE completion.
- Second ciphertext A=2 after the first result (no new N/D) → start pulse with a=2, n=33, d=7. Model returns 29 → last TX byte 0x1D.
- Reset asserted mid-S_WRITE (byte 10) → read=write=0 next cycle, state S_QUERY_RX, phase LOAD_N. A full reload then produces the correct result.
- Spurious i_core_finished during S_READ → ignored, no TX writes until the real finish.

Source files
------------

// File: rtl/rsa_pkg.sv
// Shared types and default UART register map for the RSA256 Avalon-MM wrapper.
package rsa_pkg;

    typedef enum logic [2:0] {
        S_QUERY_RX,
        S_READ,
        S_START,
        S_WAIT_CALC,
        S_QUERY_TX,
        S_WRITE
    } state_t;

    typedef enum logic [1:0] {
        LOAD_N,
        LOAD_D,
        LOAD_A
    } phase_t;

    localparam int unsigned DEF_RX_BASE     = 0;
    localparam int unsigned DEF_TX_BASE     = 1;
    localparam int unsigned DEF_STATUS_BASE = 2;
    localparam int unsigned DEF_RX_OK_BIT   = 7;
    localparam int unsigned DEF_TX_OK_BIT   = 6;
    localparam int unsigned DEF_IN_BYTES    = 32;
    localparam int unsigned DEF_OUT_BYTES   = 31;

endpackage

// File: rtl/rsa_avm_wrapper.sv
// Avalon-MM master feeding N/D/A from a UART to the RSA256 core and
// streaming the result back out; N and D persist across ciphertext blocks.
module rsa_avm_wrapper
    import rsa_pkg::*;
#(
    parameter int unsigned RX_BASE     = DEF_RX_BASE,
    parameter int unsigned TX_BASE     = DEF_TX_BASE,
    parameter int unsigned STATUS_BASE = DEF_STATUS_BASE,
    parameter int unsigned RX_OK_BIT   = DEF_RX_OK_BIT,
    parameter int unsigned TX_OK_BIT   = DEF_TX_OK_BIT,
    parameter int unsigned IN_BYTES    = DEF_IN_BYTES,
    parameter int unsigned OUT_BYTES   = DEF_OUT_BYTES
) (
    input  logic         i_clk,
    input  logic         i_rst,
    output logic [4:0]   o_avm_address,
    output logic         o_avm_read,
    input  logic [31:0]  i_avm_readdata,
    output logic         o_avm_write,
    output logic [31:0]  o_avm_writedata,
    input  logic         i_avm_waitrequest,
    output logic         o_core_start,
    output logic [255:0] o_core_a,
    output logic [255:0] o_core_d,
    output logic [255:0] o_core_n,
    input  logic [255:0] i_core_result,
    input  logic         i_core_finished
);

    localparam int unsigned CNT_W     = $clog2(IN_BYTES);
    localparam int unsigned DROP_BITS = 8 * (IN_BYTES - OUT_BYTES);

    localparam logic [4:0]       ADDR_RX     = 5'(RX_BASE);
    localparam logic [4:0]       ADDR_TX     = 5'(TX_BASE);
    localparam logic [4:0]       ADDR_STATUS = 5'(STATUS_BASE);
    localparam logic [CNT_W-1:0] IN_LAST     = CNT_W'(IN_BYTES - 1);
    localparam logic [CNT_W-1:0] OUT_LAST    = CNT_W'(OUT_BYTES - 1);

    state_t           state_q, state_d;
    phase_t           phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [255:0]     n_q, n_d, d_q, d_d, a_q, a_d;
    logic [255:0]     res_q, res_d;
    logic [4:0]       addr_q, addr_d;
    logic             read_q, read_d;
    logic             write_q, write_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             start_q, start_d;

    logic             rd_done, wr_done;
    logic [7:0]       rx_byte;
    logic             unused_readdata;

    assign rd_done         = read_q && !i_avm_waitrequest;
    assign wr_done         = write_q && !i_avm_waitrequest;
    assign rx_byte         = i_avm_readdata[7:0];
    assign unused_readdata = ^i_avm_readdata;

    assign o_avm_address   = addr_q;
    assign o_avm_read      = read_q;
    assign o_avm_write     = write_q;
    assign o_avm_writedata = wdata_q;
    assign o_core_start    = start_q;
    assign o_core_n        = n_q;
    assign o_core_d        = d_q;
    assign o_core_a        = a_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_QUERY_RX;
            phase_q <= LOAD_N;
            cnt_q   <= '0;
            n_q     <= '0;
            d_q     <= '0;
            a_q     <= '0;
            res_q   <= '0;
            addr_q  <= ADDR_STATUS;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            wdata_q <= '0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            n_q     <= n_d;
            d_q     <= d_d;
            a_q     <= a_d;
            res_q   <= res_d;
            addr_q  <= addr_d;
            read_q  <= read_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            start_q <= start_d;
        end
    end

    // Requests are registered: a cycle with the request low issues it, and
    // the completion cycle drops it, which yields the mandatory idle cycle
    // between polls. While stalled, nothing below changes.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        n_d     = n_q;
        d_d     = d_q;
        a_d     = a_q;
        res_d   = res_q;
        addr_d  = addr_q;
        read_d  = read_q;
        write_d = write_q;
        wdata_d = wdata_q;
        start_d = 1'b0;

        unique case (state_q)
            S_QUERY_RX: begin
                if (!read_q) begin
                    read_d = 1'b1;
                    addr_d = ADDR_STATUS;
                end else if (rd_done) begin
                    read_d = 1'b0;
                    if (i_avm_readdata[RX_OK_BIT]) state_d = S_READ;
                end
            end
            S_READ: begin
                if (!read_q) begin
                    read_d = 1'b1;
                    addr_d = ADDR_RX;
                end else if (rd_done) begin
                    read_d = 1'b0;
                    unique case (phase_q)
                        LOAD_N:  n_d = {n_q[247:0], rx_byte};
                        LOAD_D:  d_d = {d_q[247:0], rx_byte};
                        default: a_d = {a_q[247:0], rx_byte};
                    endcase
                    if (cnt_q == IN_LAST) begin
                        cnt_d = '0;
                        unique case (phase_q)
                            LOAD_N: begin
                                phase_d = LOAD_D;
                                state_d = S_QUERY_RX;
                            end
                            LOAD_D: begin
                                phase_d = LOAD_A;
                                state_d = S_QUERY_RX;
                            end
                            default: state_d = S_START;
                        endcase
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = S_QUERY_RX;
                    end
                end
            end
            S_START: begin
                start_d = 1'b1;
                state_d = S_WAIT_CALC;
            end
            S_WAIT_CALC: begin
                if (i_core_finished) begin
                    // Pre-align so the first byte to send sits in the top byte.
                    res_d   = i_core_result << DROP_BITS;
                    cnt_d   = '0;
                    state_d = S_QUERY_TX;
                end
            end
            S_QUERY_TX: begin
                if (!read_q) begin
                    read_d = 1'b1;
                    addr_d = ADDR_STATUS;
                end else if (rd_done) begin
                    read_d = 1'b0;
                    if (i_avm_readdata[TX_OK_BIT]) state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (!write_q) begin
                    write_d = 1'b1;
                    addr_d  = ADDR_TX;
                    wdata_d = {24'b0, res_q[255:248]};
                end else if (wr_done) begin
                    write_d = 1'b0;
                    res_d   = res_q << 8;
                    if (cnt_q == OUT_LAST) begin
                        cnt_d   = '0;
                        state_d = S_QUERY_RX;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = S_QUERY_TX;
                    end
                end
            end
            default: state_d = S_QUERY_RX;
        endcase
    end

endmodule
